// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: mode/serial/parallel/burst controls in,
// register contents and burst status out.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) ();
  logic [1:0]       mode;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             ser_out_r;
  logic             ser_out_l;
  logic             busy;
  logic             done;

  modport master (
    output mode, ser_in_r, ser_in_l, par_in, start, dir, count,
    input  q, ser_out_r, ser_out_l, busy, done
  );

  modport slave (
    input  mode, ser_in_r, ser_in_l, par_in, start, dir, count,
    output q, ser_out_r, ser_out_l, busy, done
  );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register (hold / shift right / shift left / load) with a counted burst engine.
// Define USR_ROTATE_EN to make burst shifts rotate instead of consuming the serial inputs.
module universal_shift_register #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  universal_shift_register_if.slave bus
);

  localparam int unsigned MSB = WIDTH - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_r, state_d;
  logic [WIDTH-1:0] q_r, q_d;
  logic [CNT_W-1:0] rem_r, rem_d;
  logic             dir_r, dir_d;
  logic             busy_r, busy_d;
  logic             done_r, done_d;
  logic             burst_in_r, burst_in_l;

  // Fill bits used while the burst engine owns the register
`ifdef USR_ROTATE_EN
  assign burst_in_r = q_r[0];
  assign burst_in_l = q_r[MSB];
`else
  assign burst_in_r = bus.ser_in_r;
  assign burst_in_l = bus.ser_in_l;
`endif

  always_comb begin
    state_d = state_r;
    q_d     = q_r;
    rem_d   = rem_r;
    dir_d   = dir_r;
    done_d  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          // start wins over mode; a zero count only reports completion
          if (bus.count != '0) begin
            state_d = SHIFT;
            rem_d   = bus.count;
            dir_d   = bus.dir;
          end else begin
            done_d  = 1'b1;
          end
        end else begin
          case (bus.mode)
            2'b01:   q_d = {bus.ser_in_r, q_r[MSB:1]};
            2'b10:   q_d = {q_r[MSB-1:0], bus.ser_in_l};
            2'b11:   q_d = bus.par_in;
            default: q_d = q_r;
          endcase
        end
      end
      SHIFT: begin
        if (dir_r) q_d = {q_r[MSB-1:0], burst_in_l};
        else       q_d = {burst_in_r, q_r[MSB:1]};
        rem_d = rem_r - CNT_W'(1);
        if (rem_r == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      q_r     <= '0;
      rem_r   <= '0;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_d;
      q_r     <= q_d;
      rem_r   <= rem_d;
      dir_r   <= dir_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
    end
  end

  assign bus.q         = q_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ser_out_r = q_r[0];
  assign bus.ser_out_l = q_r[MSB];

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised scoreboard bench for universal_shift_register with directed scenario checks.
module tb_universal_shift_register;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(8), .CNT_W(4)) bus ();

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected {q[7:0], busy, done} after each edge
  logic [9:0] exp_q[$];

  // Reference model state
  int m_q = 0, m_rem = 0;
  bit m_busy = 0, m_done = 0, m_dir = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int shr(input int v, input int fill);
    return (v / 2) + fill * 128;
  endfunction

  function automatic int shl(input int v, input int fill);
    return ((v * 2) % 256) + fill;
  endfunction

  task automatic model(input bit rst, input int md, input int sr, input int sl,
                       input int par, input bit st, input bit d, input int cnt);
    if (rst) begin
      m_q = 0; m_busy = 0; m_done = 0; m_rem = 0;
    end else if (m_busy) begin
`ifdef USR_ROTATE_EN
      if (m_dir) m_q = shl(m_q, m_q / 128);
      else       m_q = shr(m_q, m_q % 2);
`else
      if (m_dir) m_q = shl(m_q, sl);
      else       m_q = shr(m_q, sr);
`endif
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      m_busy = (m_rem != 0);
    end else begin
      m_done = 0;
      if (st) begin
        if (cnt != 0) begin
          m_busy = 1; m_rem = cnt; m_dir = d;
        end else begin
          m_done = 1;
        end
      end else begin
        case (md)
          1: m_q = shr(m_q, sr);
          2: m_q = shl(m_q, sl);
          3: m_q = par;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input bit rst, input logic [1:0] md, input bit sr, input bit sl,
                      input logic [7:0] par, input bit st, input bit d, input logic [3:0] cnt);
    @(negedge clk);
    reset        = rst;
    bus.mode     = md;
    bus.ser_in_r = sr;
    bus.ser_in_l = sl;
    bus.par_in   = par;
    bus.start    = st;
    bus.dir      = d;
    bus.count    = cnt;
    model(rst, int'(md), int'(sr), int'(sl), int'(par), st, d, int'(cnt));
    exp_q.push_back({8'(m_q), m_busy, m_done});
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every post-edge DUT state against the scoreboard
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("q",         32'(bus.q),         32'(e[9:2]));
        chk("busy",      32'(bus.busy),      32'(e[1]));
        chk("done",      32'(bus.done),      32'(e[0]));
        chk("ser_out_r", 32'(bus.ser_out_r), 32'(e[2]));
        chk("ser_out_l", 32'(bus.ser_out_l), 32'(e[9]));
      end
    end
  end

  initial begin
    int busy_n, done_n;
    logic [7:0] exp_v;
    reset = 1'b1;
    bus.mode = 2'b00; bus.ser_in_r = 1'b0; bus.ser_in_l = 1'b0; bus.par_in = '0;
    bus.start = 1'b0; bus.dir = 1'b0; bus.count = '0;

    // Reset with random inputs
    repeat (2) step(1'b1, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 4'($urandom));
    idle(); settle();
    chk("reset_q", 32'(bus.q), 32'h00);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);

    // Manual operations
    step(1'b0, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0); settle();
    chk("man_shr", 32'(bus.q), 32'hD2);
    step(1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0); settle();
    chk("man_shl", 32'(bus.q), 32'hA4);
    repeat (3) idle();
    settle();
    chk("man_hold", 32'(bus.q), 32'hA4);
    chk("man_sor", 32'(bus.ser_out_r), 32'h0);
    chk("man_sol", 32'(bus.ser_out_l), 32'h1);

    // Burst left of 3 from 0x81
    step(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd3); settle();
`ifdef USR_ROTATE_EN
    exp_v = 8'h0C;
`else
    exp_v = 8'h08;
`endif
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (i == 3) chk("bl_q", 32'(bus.q), 32'(exp_v));
      idle(); settle();
    end
    chk("bl_busy_cycles", 32'(busy_n), 32'd3);
    chk("bl_done_pulses", 32'(done_n), 32'd1);

    // Burst isolation: load and restart attempts during a 4-shift right burst
    step(1'b0, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd4); settle();
`ifdef USR_ROTATE_EN
    exp_v = 8'hC3;
`else
    exp_v = 8'h03;
`endif
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (i == 4) chk("iso_q", 32'(bus.q), 32'(exp_v));
      if (i < 4) step(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 4'd9);
      else idle();
      settle();
    end
    chk("iso_busy_cycles", 32'(busy_n), 32'd4);
    chk("iso_done_pulses", 32'(done_n), 32'd1);

    // Count zero, then back-to-back start in the done cycle
    step(1'b0, 2'b11, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 4'd0); settle();
    chk("cz_done", 32'(bus.done), 32'h1);
    chk("cz_busy", 32'(bus.busy), 32'h0);
    chk("cz_q", 32'(bus.q), 32'h5A);
    step(1'b0, 2'b00, 1'($urandom), 1'($urandom), 8'h00, 1'b1, 1'b0, 4'd2); settle();
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      step(1'b0, 2'b00, 1'($urandom), 1'($urandom), 8'h00, 1'b0, 1'b0, 4'd0); settle();
    end
    chk("b2b_busy_cycles", 32'(busy_n), 32'd2);
    chk("b2b_done_pulses", 32'(done_n), 32'd1);

    // Reset during cycle 2 of a 5-shift burst
    step(1'b0, 2'b11, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 4'd0);
    step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd5);
    idle();
    step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0); settle();
    chk("rmb_q", 32'(bus.q), 32'h00);
    chk("rmb_busy", 32'(bus.busy), 32'h0);
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) done_n++;
      idle(); settle();
    end
    chk("rmb_no_done", 32'(done_n), 32'd0);
    step(1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 4'd1); settle();
`ifdef USR_ROTATE_EN
    exp_v = 8'h00;
`else
    exp_v = 8'h80;
`endif
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) done_n++;
      if (i == 1) chk("rmb_restart_q", 32'(bus.q), 32'(exp_v));
      step(1'b0, 2'b00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0); settle();
    end
    chk("rmb_restart_busy", 32'(busy_n), 32'd1);
    chk("rmb_restart_done", 32'(done_n), 32'd1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), 4'($urandom));
    end
    idle();
    repeat (3) settle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
